// File: rtl/neural_net.sv
// Fully connected layer: outputs[j] = sat(sum_i inputs[i]*weights[j*N_IN+i] + biases[j]), unsigned.
// Latency 2 edges from inputs/weights, 1 from biases; free-running with II=1 and no backpressure.
module neural_net #(
  parameter int N_IN   = 10,
  parameter int N_OUT  = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] inputs  [0:N_IN-1],
  input  logic [DATA_W-1:0] weights [0:N_IN*N_OUT-1],
  input  logic [DATA_W-1:0] biases  [0:N_OUT-1],
  output logic [DATA_W-1:0] outputs [0:N_OUT-1]
);

  localparam int ACC_W = 2*DATA_W + $clog2(N_IN) + 1;

  logic [ACC_W-1:0]  acc_d [0:N_OUT-1];
  logic [ACC_W-1:0]  acc_q [0:N_OUT-1];
  logic [DATA_W-1:0] sat_d [0:N_OUT-1];

  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      logic [ACC_W-1:0] a;
      a = '0;
      for (int i = 0; i < N_IN; i++) begin
        a = a + ACC_W'(inputs[i]) * ACC_W'(weights[j*N_IN+i]);
      end
      acc_d[j] = a;
    end
  end

  // ACC_W leaves headroom for the bias, so the sum itself cannot wrap.
  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      logic [ACC_W-1:0] s;
      s = acc_q[j] + ACC_W'(biases[j]);
      sat_d[j] = (|s[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : s[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < N_OUT; j++) begin
        acc_q[j]   <= '0;
        outputs[j] <= '0;
      end
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        acc_q[j]   <= acc_d[j];
        outputs[j] <= sat_d[j];
      end
    end
  end

endmodule

// File: tb/tb_neural_net.sv
// Directed bench for neural_net at default parameters with hand-computed expectations.
module tb_neural_net;

  logic       clk;
  logic       reset;
  logic [7:0] inputs  [0:9];
  logic [7:0] weights [0:99];
  logic [7:0] biases  [0:9];
  logic [7:0] outputs [0:9];
  logic [7:0] exp_out [0:9];

  int n_assert;
  int n_fail;

  neural_net #(.N_IN(10), .N_OUT(10), .DATA_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .inputs  (inputs),
    .weights (weights),
    .biases  (biases),
    .outputs (outputs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input int j, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %0d expected %0d", tag, j, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    for (int j = 0; j < 10; j++) chk(tag, j, outputs[j], exp_out[j]);
  endtask

  task automatic set_inputs(input logic [7:0] v);
    for (int i = 0; i < 10; i++) inputs[i] = v;
  endtask

  task automatic set_weights(input logic [7:0] v);
    for (int k = 0; k < 100; k++) weights[k] = v;
  endtask

  task automatic set_biases(input logic [7:0] v);
    for (int j = 0; j < 10; j++) biases[j] = v;
  endtask

  task automatic set_exp(input logic [7:0] v);
    for (int j = 0; j < 10; j++) exp_out[j] = v;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;

    // Reset held with arbitrary data on the inputs.
    reset = 1'b0;
    for (int i = 0; i < 10; i++) inputs[i] = 8'($urandom);
    for (int k = 0; k < 100; k++) weights[k] = 8'($urandom);
    for (int j = 0; j < 10; j++) biases[j] = 8'($urandom);
    step(); step(); step();
    set_exp(8'd0);
    chk_all("reset_hold");

    // Reference vector: acc_j = 450j+120, plus bias j.
    for (int i = 0; i < 10; i++) inputs[i] = 8'(9 - i);
    for (int k = 0; k < 100; k++) weights[k] = 8'(k);
    for (int j = 0; j < 10; j++) biases[j] = 8'(j);
    reset = 1'b1;
    step();
    // After one edge the accumulators were still zero, so only biases show.
    for (int j = 0; j < 10; j++) exp_out[j] = 8'(j);
    chk_all("first_edge_bias_only");
    step();
    set_exp(8'd255);
    exp_out[0] = 8'd120;
    chk_all("reference");

    // Zero weights: outputs equal biases.
    set_weights(8'd0);
    for (int j = 0; j < 10; j++) biases[j] = 8'(3*j + 1);
    step(); step();
    for (int j = 0; j < 10; j++) exp_out[j] = 8'(3*j + 1);
    chk_all("bias_pass");

    // Bias-only change shows up after a single edge.
    for (int j = 0; j < 10; j++) biases[j] = 8'(2*j);
    step();
    for (int j = 0; j < 10; j++) exp_out[j] = 8'(2*j);
    chk_all("bias_latency");

    // Saturation boundary: 250 + bias.
    set_inputs(8'd0);
    inputs[0] = 8'd1;
    set_weights(8'd0);
    for (int j = 0; j < 10; j++) weights[j*10] = 8'd250;
    set_biases(8'd4);
    step(); step();
    set_exp(8'd254);
    chk_all("sat_below");
    set_biases(8'd5);
    step();
    set_exp(8'd255);
    chk_all("sat_exact");
    set_biases(8'd6);
    step();
    chk_all("sat_clamp");

    set_inputs(8'd255);
    set_weights(8'd255);
    set_biases(8'd255);
    step(); step();
    chk_all("sat_all_max");

    // Throughput: a new vector every cycle, each result exactly 2 edges later.
    set_weights(8'd1);
    set_biases(8'd0);
    set_inputs(8'd1);
    step();
    chk("tp_edge1_old", 0, outputs[0], 8'd255);
    set_inputs(8'd2);
    step();
    chk("tp_c1", 0, outputs[0], 8'd10);
    chk("tp_c1", 9, outputs[9], 8'd10);
    set_inputs(8'd3);
    step();
    chk("tp_c2", 0, outputs[0], 8'd20);
    chk("tp_c2", 5, outputs[5], 8'd20);
    set_inputs(8'd4);
    step();
    chk("tp_c3", 0, outputs[0], 8'd30);
    chk("tp_c3", 9, outputs[9], 8'd30);

    // Asynchronous reset between edges clears outputs immediately.
    @(posedge clk);
    #2;
    chk("pre_async", 3, outputs[3], 8'd40);
    reset = 1'b0;
    #1;
    set_exp(8'd0);
    chk_all("async_reset");
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("post_reset_edge1", 0, outputs[0], 8'd0);
    chk("post_reset_edge1", 9, outputs[9], 8'd0);
    step();
    set_exp(8'd40);
    chk_all("post_reset_edge2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/neural_net.md
Name: neural_net

Overview:
- Single fully connected neural-network layer with N_IN inputs and N_OUT neurons.
- Each output is the unsigned dot product of the input vector with that neuron's weight row, plus a bias, saturated to DATA_W bits.
- The block is free-running, with no start/done handshake. It recomputes every cycle from whatever sits on its input arrays.
- It is used as a building block of the fully connected network datapath.

Parameters:
- N_IN, 10, number of layer inputs (and weights per neuron)
- N_OUT, 10, number of neurons/outputs
- DATA_W, 8, width of every input, weight, bias and output element

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous reset, active-low (0 = reset asserted)
- inputs  input  [0:N_IN-1] x DATA_W  unpacked array of layer activations, unsigned
- weights  input  [0:N_IN*N_OUT-1] x DATA_W  unpacked array of weights, unsigned. Element k = j*N_IN + i connects input i to neuron j.
- biases  input  [0:N_OUT-1] x DATA_W  per-neuron bias, unsigned
- outputs  output  [0:N_OUT-1] x DATA_W  registered neuron results, unsigned

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. It is named reset in the codebase, despite the active-low polarity.
- Reset (reset==0, takes effect immediately regardless of clk):
  - All outputs = 0.
  - All internal pipeline registers = 0.
- Reset held low: outputs stay 0.
- First outputs after release: valid on the 2nd rising edge of clk after reset goes high, provided inputs are stable.
- Arithmetic, all unsigned:
  - acc_j = sum over i of inputs[i] * weights[j*N_IN+i].
  - Accumulator width is 2*DATA_W + clog2(N_IN) + 1, so it never overflows.
  - sum_j = acc_j + biases[j], computed at full width.
  - outputs[j] = sum_j if sum_j <= 2^DATA_W-1, else 2^DATA_W-1 (saturate; no wrap).
  - No activation function beyond saturation. Because the datapath is unsigned, results are never negative.
- Pipeline, 2 stages, initiation interval 1:
  - Stage 1 (edge n): register acc_j for all j. All N_OUT*N_IN products are computed in parallel, using the inputs/weights present before edge n.
  - Stage 2 (edge n+1): register saturated acc_j + biases[j] into outputs[j]. Biases are sampled at edge n+1.
- Latency:
  - Any change of inputs or weights appears on outputs 2 clock edges later.
  - A change of biases alone appears 1 edge later.
- Outputs change only on rising clk edges or on asynchronous reset assertion.
- There is no combinational path from inputs, weights or biases to outputs.
- Inputs may change every cycle. Each cycle's vector produces its own result 2 cycles later, with no loss or stall.
- Reset mid-operation: in-flight pipeline contents are discarded. Outputs go to 0 at once. Computation restarts after release with 2-cycle latency.
- Boundaries:
  - Sums exactly 2^DATA_W-1 pass through unchanged.
  - 2^DATA_W and above clamp to 2^DATA_W-1.
  - All-zero weights give outputs = biases.
- Parameter legality: N_IN >= 1, N_OUT >= 1, DATA_W >= 2. No other restrictions.

Test Plan:
- Reset: hold reset=0 with arbitrary inputs and toggle clk -> all outputs 0. Release reset with stable inputs -> outputs valid after 2 edges.
- Reference vector, defaults: inputs[i]=9-i, biases[j]=j, weights[k]=k. After >=2 edges, expect outputs[j] = 451*j + 120 saturated, i.e. outputs = {120, 255, 255, 255, 255, 255, 255, 255, 255, 255}.
- Bias pass-through: all weights 0, biases[j]=3*j+1 -> outputs[j] = 3*j+1 ({1,4,...,28}).
- Saturation edge:
  - inputs[0]=1, other inputs 0, weights[j*10]=250, bias[j]=5 -> outputs[j]=255 (exact).
  - Same with bias[j]=6 -> 255 (clamped, not 0).
  - All inputs and weights 255, biases 255 -> 255.
- Throughput/latency: each cycle apply inputs = all c (c = 1,2,3), weights all 1, biases 0. Expect outputs 10, 20, 30 on consecutive cycles, each appearing exactly 2 edges after its input.
- Async reset mid-stream: during the throughput test, drive reset=0 between edges -> outputs 0 immediately. After release, first nonzero result appears 2 edges later.
